// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the multiplexed 4-digit display scanner.
package seg_pkg;

  localparam int unsigned NumDigits     = 4;
  localparam int unsigned DefRefreshDiv = 50000;
  localparam int unsigned DefBlankCyc   = 500;

  typedef enum logic {
    StBlank = 1'b0,
    StDrive = 1'b1
  } seg_state_e;

  function automatic logic [3:0] digit_nibble(input logic [15:0] word, input logic [1:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [NumDigits-1:0] digit_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Loadable down-counter timing one BLANK or DRIVE interval; tc_o marks its last cycle.
module seg_tick_gen #(
  parameter int unsigned Width = 21
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] cur_len_i,
  input  logic [Width-1:0] nxt_len_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // cnt_q == 0 only after reset: that cycle is the first of a cur_len_i-long interval.
  // Otherwise cnt_q counts remaining cycles down to 1, then reloads for the next interval.
  always_comb begin
    tc_o = (cnt_q == Width'(1)) || ((cnt_q == '0) && (cur_len_i == Width'(1)));
    if (tc_o) begin
      cnt_d = nxt_len_i;
    end else if (cnt_q == '0) begin
      cnt_d = cur_len_i - Width'(1);
    end else begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit hex display scanner with blanking gaps and a
// double-buffered load interface that only swaps contents at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DefRefreshDiv,
  parameter int unsigned BLANK_CYC   = DefBlankCyc
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 load,
  output logic                 ready,
  input  logic [15:0]          data,
  input  logic [NumDigits-1:0] blank_mask,
  output logic [3:0]           hex_out,
  output logic [NumDigits-1:0] digit_sel,
  output logic                 frame_done
);

  localparam int unsigned MaxLen = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);
  localparam logic [CntW-1:0] DriveLen = CntW'(REFRESH_DIV);
  localparam logic [CntW-1:0] BlankLen = CntW'(BLANK_CYC);

  seg_state_e           state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          active_q, active_d, pend_q, pend_d;
  logic [NumDigits-1:0] mask_act_q, mask_act_d, pend_mask_q, pend_mask_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [3:0]           hex_q, hex_d;
  logic [NumDigits-1:0] en_q, en_d;
  logic                 fd_q;
  logic                 tc, boundary, xfer;
  logic [CntW-1:0]      cur_len, nxt_len;

  assign cur_len = (state_q == StDrive) ? DriveLen : BlankLen;
  assign nxt_len = (state_q == StDrive) ? BlankLen : DriveLen;

  seg_tick_gen #(
    .Width (CntW)
  ) u_tick_gen (
    .clk_i     (clk),
    .rst_i     (rst),
    .cur_len_i (cur_len),
    .nxt_len_i (nxt_len),
    .tc_o      (tc)
  );

  assign ready    = ~pend_vld_q;
  assign xfer     = load & ready;
  assign boundary = (state_q == StDrive) && tc && (idx_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    active_d    = active_q;
    mask_act_d  = mask_act_q;
    pend_d      = pend_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;

    if (tc) begin
      if (state_q == StBlank) begin
        state_d = StDrive;
      end else begin
        state_d = StBlank;
        idx_d   = idx_q + 2'd1;
      end
    end

    // A transfer cannot coincide with a copy: ready is low whenever pending is full.
    if (boundary && pend_vld_q) begin
      active_d   = pend_q;
      mask_act_d = pend_mask_q;
      pend_vld_d = 1'b0;
    end else if (xfer) begin
      pend_d      = data;
      pend_mask_d = blank_mask;
      pend_vld_d  = 1'b1;
    end

    // Outputs are registered from next-state values so they move with the state.
    hex_d = digit_nibble(active_d, idx_d);
    en_d  = '0;
    if ((state_d == StDrive) && !mask_act_d[idx_d]) begin
      en_d = digit_onehot(idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StBlank;
      idx_q       <= 2'd0;
      active_q    <= '0;
      mask_act_q  <= '1;
      pend_q      <= '0;
      pend_mask_q <= '0;
      pend_vld_q  <= 1'b0;
      hex_q       <= '0;
      en_q        <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      mask_act_q  <= mask_act_d;
      pend_q      <= pend_d;
      pend_mask_q <= pend_mask_d;
      pend_vld_q  <= pend_vld_d;
      hex_q       <= hex_d;
      en_q        <= en_d;
      fd_q        <= boundary;
    end
  end

  assign hex_out    = hex_q;
  assign digit_sel  = mode ? ~en_q : en_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int unsigned RDiv  = 4;
  localparam int unsigned BCyc  = 1;
  localparam int unsigned Slot  = BCyc + RDiv;
  localparam int unsigned Frame = 4 * Slot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  blank_mask = '0;
  logic        ready;
  logic [3:0]  hex_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .REFRESH_DIV (RDiv),
    .BLANK_CYC   (BCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .load       (load),
    .ready      (ready),
    .data       (data),
    .blank_mask (blank_mask),
    .hex_out    (hex_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  // Model: k = cycles since reset release; display content tracked per frame.
  int          k;
  logic [15:0] m_active, m_pend;
  logic [3:0]  m_mask, m_pmask;
  logic        m_pv;
  int          n_vec;
  int          n_err;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    m_active = '0;
    m_mask   = 4'hF;
    m_pend   = '0;
    m_pmask  = '0;
    m_pv     = 1'b0;
  endtask

  task automatic check_cycle();
    int         p;
    int         dig;
    logic       drv;
    logic [3:0] en;
    logic [3:0] sel;
    p   = k % Frame;
    dig = p / Slot;
    drv = (p % Slot) >= BCyc;
    en  = (drv && !m_mask[dig]) ? 4'(1 << dig) : 4'h0;
    sel = mode ? ~en : en;
    cmp("digit_sel", 16'(digit_sel), 16'(sel));
    cmp("hex_out", 16'(hex_out), 16'(4'(m_active >> (4 * dig))));
    cmp("ready", 16'(ready), 16'(!m_pv));
    cmp("frame_done", 16'(frame_done), 16'(k > 0 && p == 0));
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] m);
    check_cycle();
    load       = ld;
    data       = d;
    blank_mask = m;
    @(posedge clk);
    if ((k % Frame) == Frame - 1 && m_pv) begin
      m_active = m_pend;
      m_mask   = m_pmask;
      m_pv     = 1'b0;
    end else if (ld && !m_pv) begin
      m_pend  = d;
      m_pmask = m;
      m_pv    = 1'b1;
    end
    k++;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Asynchronous: outputs must be at reset values 1 ns after rst rises.
  task automatic do_reset(input logic md);
    rst  = 1'b1;
    mode = md;
    #1;
    model_reset();
    cmp("rst_digit_sel", 16'(digit_sel), md ? 16'h000F : 16'h0000);
    cmp("rst_ready", 16'(ready), 16'h0001);
    cmp("rst_hex_out", 16'(hex_out), 16'h0000);
    cmp("rst_frame_done", 16'(frame_done), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        rl;
    logic [15:0] rd;
    logic [3:0]  rm;
    n_vec = 0;
    n_err = 0;
    model_reset();
    @(negedge clk);

    // Dark first frame, then 1234 with an ignored second load.
    do_reset(1'b1);
    repeat (Frame) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h1234, 4'h0);
    step(1'b1, 16'h5555, 4'h0);
    repeat (2 * Frame) step(1'b0, 16'h0, 4'h0);

    // Load on the boundary edge with pending empty.
    while ((k % Frame) != Frame - 1) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'hABCD, 4'h0);
    repeat (2 * Frame) step(1'b0, 16'h0, 4'h0);

    // Common anode, digit 2 masked, reset during digit 2 DRIVE.
    do_reset(1'b0);
    step(1'b1, 16'h9876, 4'b0100);
    while (k < int'(Frame + 2 * Slot + BCyc + 1)) step(1'b0, 16'h0, 4'h0);
    do_reset(1'b0);
    repeat (Frame) step(1'b0, 16'h0, 4'h0);

    // Random loads across several reset segments.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(1'($urandom_range(0, 1)));
      for (int i = 0; i < 300; i++) begin
        rl = ($urandom_range(0, 3) == 0);
        rd = 16'($urandom);
        rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        step(rl, rd, rm);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, DRIVE cycles per digit (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYC, default 500, all-digits-off cycles between digits (anti-ghosting); legal range 1..2^16.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mode  input  1  1 = common cathode, 0 = common anode; static during operation.
REQ-006 SHALL have port load  input  1  request to accept data and blank_mask.
REQ-007 SHALL have port ready  output  1  1 = pending buffer empty, so load is accepted.
REQ-008 SHALL have port data  input  16  four hex nibbles; [3:0] = digit 0, [15:12] = digit 3.
REQ-009 SHALL have port blank_mask  input  4  bit i = 1 keeps digit i dark.
REQ-010 SHALL have port hex_out  output  4  nibble of the digit being driven; feeds the hex-to-7-segment decoder.
REQ-011 SHALL have port digit_sel  output  4  one-hot digit enable; mode = 1 active-low, mode = 0 active-high.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at every frame boundary.

Function
REQ-013 SHALL run a two-state FSM, BLANK and DRIVE, with a cycle counter and a 2-bit digit index idx.
REQ-014 BLANK: SHALL hold all digit enables inactive for exactly BLANK_CYC cycles, then enter DRIVE with the same idx.
REQ-015 DRIVE: SHALL assert enable bit idx for exactly REFRESH_DIV cycles, unless blank_mask_active[idx] = 1, in which case all enables stay inactive for those cycles.
REQ-016 On leaving DRIVE, SHALL enter BLANK with idx+1, wrapping 3 -> 0.
REQ-017 The DRIVE -> BLANK transition with idx = 3 is the frame boundary; one frame = 4*(BLANK_CYC+REFRESH_DIV) cycles.
REQ-018 hex_out SHALL equal active_data[4*idx+3:4*idx] throughout both BLANK and DRIVE.
REQ-019 hex_out and the internal enables SHALL be registered, changing on the same edge as the state change.
REQ-020 The digit_sel polarity inversion by mode SHALL be combinational from the registered enables.
REQ-021 Handshake: a transfer occurs on a clock edge where load = 1 and ready = 1; it captures data and blank_mask into the pending buffer and sets pending-valid.
REQ-022 ready SHALL equal NOT pending-valid, from a register.
REQ-023 load while ready = 0 SHALL be ignored; no stall and no error.
REQ-024 At a frame boundary with pending-valid = 1, SHALL copy pending into active_data / blank_mask_active and clear pending-valid, so ready rises the next cycle.
REQ-025 No tearing: active_data SHALL change only at frame boundaries.
REQ-026 Simultaneous transfer and frame boundary with pending empty: the new data SHALL go to pending only and display from the next boundary.
REQ-027 frame_done SHALL be asserted for one cycle on the boundary edge, whether or not a copy occurs.

Reset
REQ-028 While rst = 1: state = BLANK, idx = 0, counter = 0, active_data = 0, blank_mask_active = 4'hF, pending-valid = 0.
REQ-029 While rst = 1: ready = 1, hex_out = 0, frame_done = 0, enables inactive (digit_sel = 4'hF if mode = 1, 4'h0 if mode = 0).
REQ-030 Reset asserted mid-frame SHALL discard pending and active contents immediately, asynchronously.
REQ-031 After reset release, the first DRIVE SHALL begin BLANK_CYC cycles later, on digit 0.

Structure
REQ-032 Shared package seg_pkg SHALL hold the FSM state encoding, the digit-count constant (4) and the default REFRESH_DIV / BLANK_CYC values.
REQ-033 SHALL instantiate one sub-module, seg_tick_gen: a loadable down-counter producing a terminal-count pulse, reused for both BLANK and DRIVE timing.
REQ-034 The hex-to-segment decoder SHALL remain outside this block.

Verification (REFRESH_DIV = 4, BLANK_CYC = 1)
REQ-035 Reset release, no load -> digit_sel (mode 1) stays 4'hF for the whole first frame; frame_done pulses every 20 cycles.
REQ-036 Load data = 16'h1234, blank_mask = 0 before the first boundary -> next frame drives digit_sel 1110/1101/1011/0111 for 4 cycles each with hex_out 4/3/2/1, 1 dark cycle between digits.
REQ-037 Second load while ready = 0 -> ignored; the first pending value is displayed and ready rises 1 cycle after the boundary.
REQ-038 Load 16'hABCD on the boundary edge with pending empty -> displayed from the following frame, not the current one.
REQ-039 blank_mask = 4'b0100, mode = 0 -> digit_sel stays 4'h0 during digit 2's DRIVE; other digits show 0001/0010/1000.
REQ-040 Assert rst during digit 2's DRIVE -> digit_sel inactive, ready = 1 and hex_out = 0 on the same cycle; after release, digit 0 is driven BLANK_CYC cycles later with hex_out = 0.
